// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column-multiplexed row sampling, debounced press/release, one pulse per press.
// Optional KEYPAD_SHIFT_EN keeps the last four accepted codes in a 16-bit digit shift register.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic        multi_key,
    output logic [15:0] digits
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t           state, state_nx;
    logic [3:0]       row_s1, row_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [15:0]      map, cur_map;
    logic             sample, scan_done;
    logic [4:0]       n_keys;
    logic [3:0]       scan_code;
    logic             scan_none, scan_single;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]       cand, cand_nx;
    logic             accept;

    function automatic logic [3:0] key_lut(input logic [3:0] idx);
        case (idx)
            4'd0:  key_lut = 4'h1;  4'd1:  key_lut = 4'h2;  4'd2:  key_lut = 4'h3;  4'd3:  key_lut = 4'hA;
            4'd4:  key_lut = 4'h4;  4'd5:  key_lut = 4'h5;  4'd6:  key_lut = 4'h6;  4'd7:  key_lut = 4'hB;
            4'd8:  key_lut = 4'h7;  4'd9:  key_lut = 4'h8;  4'd10: key_lut = 4'h9;  4'd11: key_lut = 4'hC;
            4'd12: key_lut = 4'h0;  4'd13: key_lut = 4'hF;  4'd14: key_lut = 4'hE;  default: key_lut = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign sample    = (div_cnt == DIV_LAST);
    assign scan_done = sample && (col_idx == 2'd3);
    assign col_out   = ~(4'b0001 << col_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (sample) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Current column's rows merged into the key map; on scan_done this is the complete scan.
    always_comb begin
        cur_map = map;
        if (sample)
            for (int r = 0; r < 4; r++)
                cur_map[{2'(r), col_idx}] = ~row_s2[r];
    end

    always_comb begin
        n_keys    = '0;
        scan_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            n_keys = n_keys + {4'b0, cur_map[i]};
            if (cur_map[i]) scan_code = key_lut(4'(i));
        end
    end

    assign scan_none   = (n_keys == 5'd0);
    assign scan_single = (n_keys == 5'd1);
    assign cnt_inc     = cnt + CNT_ONE;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        accept   = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: if (scan_single) begin
                    cand_nx = scan_code;
                    if (DB_LAST == CNT_ONE) begin
                        state_nx = PRESSED;
                        accept   = 1'b1;
                    end else begin
                        state_nx = DEBOUNCE;
                        cnt_nx   = CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (!scan_single) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (scan_code != cand) begin
                        cand_nx = scan_code;
                        cnt_nx  = CNT_ONE;
                    end else if (cnt_inc == DB_LAST) begin
                        state_nx = PRESSED;
                        cnt_nx   = '0;
                        accept   = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                PRESSED: if (scan_none) begin
                    if (DB_LAST == CNT_ONE) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = RELEASE;
                        cnt_nx   = CNT_ONE;
                    end
                end
                default: begin
                    // Any key during release debounce resumes the held press without a new pulse.
                    if (!scan_none) begin
                        state_nx = PRESSED;
                        cnt_nx   = '0;
                    end else if (cnt_inc == DB_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'h0;
            map       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            map       <= cur_map;
            key_valid <= accept;
            if (accept)    key_code  <= cand_nx;
            if (scan_done) multi_key <= (n_keys > 5'd1);
        end
    end

    assign key_held = (state == PRESSED) || (state == RELEASE);

`ifdef KEYPAD_SHIFT_EN
    always_ff @(posedge clk) begin
        if (rst)         digits <= 16'h0000;
        else if (accept) digits <= {digits[11:0], cand_nx};
    end
`else
    assign digits = 16'h0000;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: keypad model shorts row to column for pressed keys.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid, key_held, multi_key;
    logic [15:0] digits;
    logic [15:0] keys = 16'h0;

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic [3:0] exp_q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .multi_key(multi_key), .digits(digits)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(keys[4*r +: 4] & ~col_out);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every key_valid cycle pops one expected code.
    initial begin
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                pulse_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got code %h expected no pulse", key_code);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (key_code !== e) begin
                        failures++;
                        $display("FAIL pulse_code: got %h expected %h", key_code, e);
                    end
                end
            end
        end
    end

    task automatic wait_pulse(input string name, input int bound);
        int start;
        bit seen;
        start = pulse_cnt;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk);
            if (pulse_cnt != start) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: got no pulse expected pulse within %0d cycles", name, bound);
        end
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_release(input int idx, input logic [3:0] code);
        exp_q.push_back(code);
        keys[idx] = 1'b1;
        wait_pulse("press", 60);
        keys[idx] = 1'b0;
        cycles(60);
    endtask

    initial begin
        int pc;
        // Reset state and column stepping
        cycles(3);
        chk("rst_col", col_out, 16'hE);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_multi", multi_key, 1'b0);
        chk("rst_digits", digits, 16'h0);
        rst = 1'b0;
        cycles(4); chk("col1", col_out, 16'hD);
        cycles(4); chk("col2", col_out, 16'hB);
        cycles(4); chk("col3", col_out, 16'h7);
        cycles(4); chk("col_wrap", col_out, 16'hE);

        // Press '6' and hold
        exp_q.push_back(4'h6);
        keys[6] = 1'b1;
        wait_pulse("press6", 60);
        chk("held6", key_held, 1'b1);
        pc = pulse_cnt;
        cycles(160);
        chk("no_repeat", 16'(pulse_cnt), 16'(pc));
        chk("held6_still", key_held, 1'b1);

        // Release '6': one empty scan is not enough, two are
        keys[6] = 1'b0;
        cycles(16);
        chk("held_after_1scan", key_held, 1'b1);
        cycles(40);
        chk("released6", key_held, 1'b0);
        chk("code_kept", key_code, 4'h6);

        // Bounce '9' on alternate scans
        pc = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            keys[10] = ~keys[10];
            cycles(16);
            chk("bounce_held", key_held, 1'b0);
        end
        keys[10] = 1'b0;
        cycles(40);
        chk("bounce_no_pulse", 16'(pulse_cnt), 16'(pc));

        // Press 'D'
        press_release(15, 4'hD);
        chk("codeD", key_code, 4'hD);

        // Multi-key: '1'+'2', then release '2'
        pc = pulse_cnt;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        cycles(40);
        chk("multi_set", multi_key, 1'b1);
        chk("multi_no_pulse", 16'(pulse_cnt), 16'(pc));
        exp_q.push_back(4'h1);
        keys[1] = 1'b0;
        wait_pulse("press1", 60);
        cycles(20);
        chk("multi_clear", multi_key, 1'b0);
        keys[0] = 1'b0;
        cycles(60);

        // Reset mid-press on '5'
        exp_q.push_back(4'h5);
        keys[5] = 1'b1;
        wait_pulse("press5", 60);
        rst = 1'b1;
        cycles(1);
        chk("mid_rst_held", key_held, 1'b0);
        chk("mid_rst_code", key_code, 4'h0);
        chk("mid_rst_col", col_out, 16'hE);
        chk("mid_rst_digits", digits, 16'h0);
        rst = 1'b0;
        exp_q.push_back(4'h5);
        wait_pulse("repress5", 60);
        chk("code5", key_code, 4'h5);
        keys[5] = 1'b0;
        cycles(60);

`ifdef KEYPAD_SHIFT_EN
        press_release(0, 4'h1);
        press_release(1, 4'h2);
        press_release(2, 4'h3);
        press_release(3, 4'hA);
        chk("digits", digits, 16'h123A);
`else
        press_release(2, 4'h3);
        chk("digits_off", digits, 16'h0);
`endif

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
